// File: rtl/booth_pkg.sv
// Shared types and sizing helpers for the radix-2 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    function automatic int cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

    localparam int CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/booth_addsub.sv
// Combinational adder/subtractor; subtraction is a + ~b + 1, carry-out dropped.
module booth_addsub #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + (b ^ {WIDTH{sub}}) + {{(WIDTH-1){1'b0}}, sub};

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier: one add/sub/no-op plus an
// arithmetic right shift per cycle, WIDTH cycles per product.
module booth_multiplier
    import booth_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = cnt_w(WIDTH);

    state_t           state, next_state;
    logic [WIDTH:0]   acc, m_reg, addsub_sum, acc_sel, acc_next;
    logic [WIDTH-1:0] q_reg, q_next;
    logic             q_m1;
    logic [CW-1:0]    cnt;
    logic             accept, last;

    // Booth pair 10 subtracts M, 01 adds it; Q[0] alone picks the direction.
    booth_addsub #(.WIDTH(WIDTH + 1)) u_addsub (
        .a   (acc),
        .b   (m_reg),
        .sub (q_reg[0]),
        .sum (addsub_sum)
    );

    assign accept = start && (state == IDLE || state == DONE);
    assign last   = (cnt == CW'(WIDTH - 1));

    always_comb begin
        acc_sel  = (q_reg[0] ^ q_m1) ? addsub_sum : acc;
        acc_next = {acc_sel[WIDTH], acc_sel[WIDTH:1]};
        q_next   = {acc_sel[0], q_reg[WIDTH-1:1]};
    end

    always_comb begin
        // NOTE: default first so every path assigns next_state and no latch is inferred.
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (last)  next_state = DONE;
            DONE:    next_state = start ? CALC : IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
            acc     <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            q_m1    <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= next_state;
            busy  <= (next_state == CALC);
            done  <= (next_state == DONE);
            if (accept) begin
                acc   <= '0;
                q_reg <= multiplier;
                q_m1  <= 1'b0;
                m_reg <= {multiplicand[WIDTH-1], multiplicand};
                cnt   <= '0;
            end else if (state == CALC) begin
                acc   <= acc_next;
                q_reg <= q_next;
                q_m1  <= q_reg[0];
                cnt   <= cnt + CW'(1);
                if (last) product <= {acc_next[WIDTH-1:0], q_next};
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier against a plain signed-multiply model.
module tb_booth_multiplier;

    localparam int W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [W-1:0]     multiplicand;
    logic [W-1:0]     multiplier;
    logic             busy;
    logic             done;
    logic [2*W-1:0]   product;

    int n_checks = 0;
    int n_fail   = 0;

    booth_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] m, input logic [W-1:0] q);
        int a, b, p;
        a = int'($signed(m));
        b = int'($signed(q));
        p = a * b;
        return p[2*W-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accepts one operation and waits (bounded) for done; reports latency in edges.
    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] q,
                          output int lat, output logic [2*W-1:0] p, output bit ok);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        tick();
        start = 1'b0;
        lat = 0;
        ok  = 1'b0;
        for (int i = 1; i <= 4 * W; i++) begin
            tick();
            if (done) begin
                lat = i;
                ok  = 1'b1;
                break;
            end
        end
        p = product;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, done, product} !== {1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_state: busy=%0b done=%0b product=%h, want 0 0 0000", busy, done, product);
        end
    endtask

    task automatic test_timing();
        logic [2*W-1:0] exp_p;
        exp_p = model(8'd3, 8'd5);
        start = 1'b1;
        multiplicand = 8'd3;
        multiplier   = 8'd5;
        tick();
        start = 1'b0;
        for (int k = 0; k < W; k++) begin
            n_checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL timing_busy_edge_%0d: busy=%0b done=%0b, want 1 0", k, busy, done);
            end
            tick();
        end
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b1 || product !== exp_p || exp_p !== 16'h000F) begin
            n_fail++;
            $display("FAIL timing_done: busy=%0b done=%0b product=%h, want 0 1 000f", busy, done, product);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h000F) begin
            n_fail++;
            $display("FAIL timing_done_fall: busy=%0b done=%0b product=%h, want 0 0 000f", busy, done, product);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0]   ms [6] = '{8'hF9, 8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};
        logic [W-1:0]   qs [6] = '{8'h06, 8'h80, 8'h80, 8'hFF, 8'hFF, 8'h80};
        logic [2*W-1:0] ex [6] = '{16'hFFD6, 16'h4000, 16'hC080, 16'h0000, 16'h0001, 16'hFF80};
        int lat;
        logic [2*W-1:0] p;
        bit ok;
        for (int i = 0; i < 6; i++) begin
            run_op(ms[i], qs[i], lat, p, ok);
            n_checks++;
            if (!ok || lat != W || p !== ex[i] || p !== model(ms[i], qs[i])) begin
                n_fail++;
                $display("FAIL directed_%0d: %h*%h got %h lat=%0d ok=%0b, want %h lat=%0d",
                         i, ms[i], qs[i], p, lat, ok, ex[i], W);
            end
            tick();
        end
    endtask

    task automatic test_random();
        int lat;
        logic [2*W-1:0] p;
        bit ok;
        logic [W-1:0] m, q;
        for (int i = 0; i < 40; i++) begin
            m = W'($urandom);
            q = W'($urandom);
            run_op(m, q, lat, p, ok);
            n_checks++;
            if (!ok || lat != W || p !== model(m, q)) begin
                n_fail++;
                $display("FAIL random_%0d: %h*%h got %h lat=%0d, want %h lat=%0d",
                         i, m, q, p, lat, model(m, q), W);
            end
            tick();
        end
    endtask

    task automatic test_start_ignored();
        logic [2*W-1:0] exp_p;
        int lat;
        exp_p = model(8'hE5, 8'h13);
        start = 1'b1;
        multiplicand = 8'hE5;
        multiplier   = 8'h13;
        tick();
        start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 4 * W; i++) begin
            if (i == 3) begin
                start = 1'b1;
                multiplicand = 8'h44;
                multiplier   = 8'h9C;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        n_checks++;
        if (lat != W || product !== exp_p) begin
            n_fail++;
            $display("FAIL start_ignored: lat=%0d product=%h, want lat=%0d product=%h", lat, product, W, exp_p);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] exp_a, exp_b;
        exp_a = model(8'h2B, 8'hD3);
        exp_b = model(8'h91, 8'h6E);
        start = 1'b1;
        multiplicand = 8'h2B;
        multiplier   = 8'hD3;
        tick();
        for (int k = 1; k <= W; k++) begin
            if (k == 5) begin
                multiplicand = 8'h91;
                multiplier   = 8'h6E;
            end
            tick();
        end
        n_checks++;
        if (done !== 1'b1 || product !== exp_a) begin
            n_fail++;
            $display("FAIL b2b_first: done=%0b product=%h, want 1 %h", done, product, exp_a);
        end
        tick();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1 || product !== exp_a) begin
            n_fail++;
            $display("FAIL b2b_restart: done=%0b busy=%0b product=%h, want 0 1 %h", done, busy, product, exp_a);
        end
        for (int k = 1; k < W; k++) begin
            tick();
            n_checks++;
            if (done !== 1'b0 || product !== exp_a) begin
                n_fail++;
                $display("FAIL b2b_hold_%0d: done=%0b product=%h, want 0 %h", k, done, product, exp_a);
            end
        end
        tick();
        n_checks++;
        if (done !== 1'b1 || product !== exp_b) begin
            n_fail++;
            $display("FAIL b2b_second: done=%0b product=%h, want 1 %h", done, product, exp_b);
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int lat;
        logic [2*W-1:0] p;
        bit ok;
        bit seen_done;
        start = 1'b1;
        multiplicand = 8'h37;
        multiplier   = 8'hA5;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if ({busy, done, product} !== {1'b0, 1'b0, 16'h0000}) begin
            n_fail++;
            $display("FAIL abort_state: busy=%0b done=%0b product=%h, want 0 0 0000", busy, done, product);
        end
        seen_done = 1'b0;
        for (int k = 0; k < 2 * W; k++) begin
            tick();
            if (done || busy) seen_done = 1'b1;
        end
        n_checks++;
        if (seen_done) begin
            n_fail++;
            $display("FAIL abort_quiet: activity after reset=%0b, want 0", seen_done);
        end
        run_op(8'hC4, 8'h1D, lat, p, ok);
        n_checks++;
        if (!ok || lat != W || p !== model(8'hC4, 8'h1D)) begin
            n_fail++;
            $display("FAIL abort_recover: product=%h lat=%0d, want %h lat=%0d", p, lat, model(8'hC4, 8'h1D), W);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_timing();
        test_directed();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
